piso_tx_scheduler: RTL and testbench
====================================

# piso_tx_scheduler

Round-robin scheduler that shares one parallel-in/serial-out shifter among NREQ requesters. It grants one requester at a time, captures that requester's word, and shifts it out MSB-first with a framing strobe. It then inserts an inter-frame gap before arbitrating again. It sits between the parallel producers and the single serial link in the sequential-circuits datapath.

## Interface
- WIDTH, 8, bits per word; 2..32
- NREQ, 4, number of requesters; 2..8
- GAP_CYCLES, 1, idle cycles in GAP state after each frame; ≥1
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  req[k]=1: requester k has a word ready
- data_in  input  NREQ*WIDTH  requester k's word at [k*WIDTH +: WIDTH]
- grant  output  NREQ  registered one-hot pulse, one cycle; word of that requester was captured
- src_id  output  clog2(NREQ)  index of requester owning current/last frame
- serial_out  output  1  registered serial data, MSB first
- frame  output  1  registered; high exactly while a valid data bit is on serial_out
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: if any req bit is high, capture on the next edge:
  - winner = first k with req[k]=1, searching from (last+1) mod NREQ upward with wrap.
  - shift_reg ← winner's data_in; grant ← onehot(winner); src_id ← winner; last ← winner; cnt ← 0; → SHIFT.
  - If no req is high, stay in IDLE and keep grant at 0.
- SHIFT, each edge:
  - serial_out ← shift_reg[WIDTH-1]; shift_reg ← shift_reg << 1; frame ← 1; cnt ← cnt+1.
  - After the WIDTH-th shift edge, → GAP.
- GAP:
  - On the first edge in GAP: frame ← 0, serial_out ← 0.
  - Stay in GAP for GAP_CYCLES cycles total, then → IDLE.
- Arbitration happens only in IDLE. req is ignored in SHIFT and GAP, and req changes mid-frame have no effect.
- Requester obligation: after seeing grant[k], deassert req[k] or present the next word before the scheduler returns to IDLE. This leaves at least WIDTH+GAP_CYCLES cycles.
- grant is 0 in every cycle except the single cycle following a capture edge.
- Reset (any time, including mid-frame):
  - state=IDLE; shift_reg, cnt, grant, src_id, serial_out, frame all 0.
  - last=NREQ-1, so requester 0 has first priority.
  - A frame in progress is abandoned, not resumed.
- Widths: cnt is clog2(WIDTH+1) bits; pointer arithmetic wraps modulo NREQ (NREQ need not be a power of 2).

## Timing
- Edge E0 = capture edge.
  - grant, src_id, busy are high in cycle E0→E1.
  - Data bit i (i=0 is the MSB) is on serial_out with frame=1 in the cycle after edge E(i+1), for i=0..WIDTH-1.
- Latency: req high in IDLE → first data bit 2 cycles later.
- Frame low (and serial_out=0) from E(WIDTH+1) for GAP_CYCLES+1 cycles between back-to-back frames.
  - Next capture is at E(WIDTH+GAP_CYCLES+1).
  - Frame period is WIDTH+GAP_CYCLES+1 cycles.
- busy falls at the edge entering IDLE, and rises at the capture edge.

## Test plan
- Reset, then req=0 for 10 cycles → grant=0, frame=0, serial_out=0, busy=0 throughout.
- Single frame, req[2]=1, data_in word2=8'hA5 (WIDTH=8, GAP_CYCLES=1):
  - grant=4'b0100 for one cycle, src_id=2.
  - serial_out=1,0,1,0,0,1,0,1 with frame=1 for exactly 8 cycles, first bit 2 cycles after req.
  - frame low 2 cycles before the next capture.
- Round-robin, all req=4'b1111 held high with distinct words 8'h11/22/33/44:
  - grants in order 0,1,2,3,0.
  - Frame starts spaced 10 cycles apart; each frame serializes its own word.
- Fairness/skip, req=4'b1001 held after requester 0 is served → next grant is 3, then 0, then 3; requesters 1 and 2 are never granted.
- Reset mid-frame: assert rst during the 4th bit of a frame → all outputs 0 immediately (asynchronous); after release with req[1]=1, requester 1 is granted before 0 only if req[0]=0 (pointer reset check).
- Mid-frame req change: flip req and data_in during SHIFT → serialized bits unaffected; the next grant reflects req as sampled in IDLE only.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// Round-robin PISO scheduler: grants one requester, shifts its word out MSB-first with a frame strobe.
// Latency: req in IDLE -> first serial bit 2 cycles later; no backpressure, req is sampled only in IDLE.
module piso_tx_scheduler #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] src_id,
  output logic                    serial_out,
  output logic                    frame,
  output logic                    busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    cnt;
  logic [GW-1:0]    gap_cnt;
  logic [IW-1:0]    last;

  logic [WIDTH-1:0] words [NREQ];
  logic             any_req;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    idx_w;
  int               idx;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      words[k] = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Search starts one past the last winner and wraps modulo NREQ.
  always_comb begin
    any_req = 1'b0;
    winner  = last;
    idx     = 0;
    idx_w   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idx_w = IW'(idx);
      if (!any_req && req[idx_w]) begin
        any_req = 1'b1;
        winner  = idx_w;
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      src_id     <= '0;
      serial_out <= 1'b0;
      frame      <= 1'b0;
      last       <= IW'(NREQ - 1);
    end else begin
      grant <= '0;
      case (state)
        IDLE: begin
          frame      <= 1'b0;
          serial_out <= 1'b0;
          if (any_req) begin
            shift_reg <= words[winner];
            grant     <= NREQ'(1) << winner;
            src_id    <= winner;
            last      <= winner;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          serial_out <= shift_reg[WIDTH-1];
          shift_reg  <= shift_reg << 1;
          frame      <= 1'b1;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          frame      <= 1'b0;
          serial_out <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler (WIDTH=8, NREQ=4, GAP_CYCLES=1): frame vector table plus reset sequences.
module tb_piso_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  grant;
  logic [1:0]  src_id;
  logic        serial_out;
  logic        frame;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  piso_tx_scheduler #(.WIDTH(8), .NREQ(4), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .grant      (grant),
    .src_id     (src_id),
    .serial_out (serial_out),
    .frame      (frame),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [31:0] data;
    bit          flip_en;
    logic [3:0]  flip_req;
    logic [31:0] flip_data;
    int          exp_id;
    logic [7:0]  exp_word;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_grant"}, 32'(grant), 32'h0);
    chk({name, "_src_id"}, 32'(src_id), 32'h0);
    chk({name, "_serial"}, 32'(serial_out), 32'h0);
    chk({name, "_frame"}, 32'(frame), 32'h0);
    chk({name, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Called at a negedge with inputs already applied and the DUT in IDLE;
  // checks the 10-cycle frame period and returns at the negedge before the next capture.
  task automatic check_frame(input int exp_id, input logic [7:0] exp_word, input bit flip_en,
                             input logic [3:0] flip_req, input logic [31:0] flip_data);
    logic [31:0] exp_grant;
    exp_grant = 32'(1) << exp_id;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("grant_pulse", 32'(grant), exp_grant);
        chk("src_id", 32'(src_id), 32'(exp_id));
        chk("busy_capture", 32'(busy), 32'h1);
        chk("frame_capture", 32'(frame), 32'h0);
      end else if (k <= 8) begin
        chk("serial_bit", 32'(serial_out), 32'(exp_word[8-k]));
        chk("frame_hi", 32'(frame), 32'h1);
        chk("grant_lo", 32'(grant), 32'h0);
        chk("busy_shift", 32'(busy), 32'h1);
      end else begin
        chk("gap_frame", 32'(frame), 32'h0);
        chk("gap_serial", 32'(serial_out), 32'h0);
        chk("gap_busy", 32'(busy), 32'h0);
      end
      if (flip_en && k == 3) begin
        req     = flip_req;
        data_in = flip_data;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0000, 32'h0, 2, 8'hA5};
    vecs[1]  = '{1'b1, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 0, 8'h11};
    vecs[2]  = '{1'b0, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 1, 8'h22};
    vecs[3]  = '{1'b0, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 2, 8'h33};
    vecs[4]  = '{1'b0, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 3, 8'h44};
    vecs[5]  = '{1'b0, 4'b1111, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 0, 8'h11};
    vecs[6]  = '{1'b0, 4'b1001, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 3, 8'h44};
    vecs[7]  = '{1'b0, 4'b1001, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 0, 8'h11};
    vecs[8]  = '{1'b0, 4'b1001, 32'h4433_2211, 1'b0, 4'b0000, 32'h0, 3, 8'h44};
    vecs[9]  = '{1'b0, 4'b0010, 32'h0000_5A00, 1'b1, 4'b1000, 32'hFFFF_FFFF, 1, 8'h5A};
    vecs[10] = '{1'b0, 4'b0101, 32'h0077_0066, 1'b0, 4'b0000, 32'h0, 2, 8'h77};

    rst     = 1'b1;
    req     = 4'b0000;
    data_in = 32'h0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_frame", 32'(frame), 32'h0);
      chk("idle_serial", 32'(serial_out), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].rst_before) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      req     = vecs[v].req;
      data_in = vecs[v].data;
      check_frame(vecs[v].exp_id, vecs[v].exp_word, vecs[v].flip_en,
                  vecs[v].flip_req, vecs[v].flip_data);
    end

    // Reset asserted during the 4th serial bit must clear outputs without a clock edge.
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    req     = 4'b0001;
    data_in = 32'h0000_00C3;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("pre_reset_frame", 32'(frame), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midframe_reset");
    @(negedge clk);
    rst     = 1'b0;
    req     = 4'b0011;
    data_in = 32'h0000_963C;
    check_frame(0, 8'h3C, 1'b0, 4'b0000, 32'h0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0010;
    check_frame(1, 8'h96, 1'b0, 4'b0000, 32'h0);

    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("final_idle_grant", 32'(grant), 32'h0);
      chk("final_idle_busy", 32'(busy), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
